// File: rtl/l1_tag_sram_ctrl_if.sv
// rtl/l1_tag_sram_ctrl_if.sv - request/response and tag-macro signal bundle for l1_tag_sram_ctrl
//
// Groups every non-clock/reset signal of the tag controller.
//   slave  : the controller (l1_tag_sram_ctrl)
//   master : requesters plus the tag macro model (drives requests and sram_dout1)
// Signals:
//   lookup_*          read request handshake; rsp_valid/rsp_tag read response
//   fill_*, inv_*     write requesters sharing the macro write port
//   flush_*           full-array clear control/status
//   sram_*            tag macro port 0 (write) and port 1 (read)
//   stat_*            lookup / forward counters (zero when the stats build option is off)
interface l1_tag_sram_ctrl_if #(
   parameter int DATA_WIDTH = 19,
   parameter int ADDR_WIDTH = 8
);
   logic                  lookup_valid;
   logic                  lookup_ready;
   logic [ADDR_WIDTH-1:0] lookup_idx;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_tag;
   logic                  fill_valid;
   logic                  fill_ready;
   logic [ADDR_WIDTH-1:0] fill_idx;
   logic [DATA_WIDTH-1:0] fill_data;
   logic                  inv_valid;
   logic                  inv_ready;
   logic [ADDR_WIDTH-1:0] inv_idx;
   logic                  flush_start;
   logic                  flush_busy;
   logic                  flush_done;
   logic                  sram_csb0;
   logic [ADDR_WIDTH-1:0] sram_addr0;
   logic [DATA_WIDTH-1:0] sram_din0;
   logic                  sram_csb1;
   logic [ADDR_WIDTH-1:0] sram_addr1;
   logic [DATA_WIDTH-1:0] sram_dout1;
   logic [15:0]           stat_lookups;
   logic [15:0]           stat_fwd;

   modport slave (
      input  lookup_valid, lookup_idx, fill_valid, fill_idx, fill_data,
             inv_valid, inv_idx, flush_start, sram_dout1,
      output lookup_ready, rsp_valid, rsp_tag, fill_ready, inv_ready,
             flush_busy, flush_done, sram_csb0, sram_addr0, sram_din0,
             sram_csb1, sram_addr1, stat_lookups, stat_fwd
   );

   modport master (
      output lookup_valid, lookup_idx, fill_valid, fill_idx, fill_data,
             inv_valid, inv_idx, flush_start, sram_dout1,
      input  lookup_ready, rsp_valid, rsp_tag, fill_ready, inv_ready,
             flush_busy, flush_done, sram_csb0, sram_addr0, sram_din0,
             sram_csb1, sram_addr1, stat_lookups, stat_fwd
   );
endinterface

// File: rtl/l1_tag_sram_ctrl.sv
// rtl/l1_tag_sram_ctrl.sv - sequencing/arbitration controller for the L1 tag array macro
//
// Shares the single macro write port between fill and invalidate requesters
// (round-robin when both ask), runs a full-array flush sweep, issues lookups
// on the read port, registers the macro's transient read data and forwards
// write data when a lookup and a write hit the same index in the same cycle.
// Ports:
//   clk   single clock for controller and both macro ports
//   rst   asynchronous active-high reset
//   bus   l1_tag_sram_ctrl_if slave modport (requests, response, flush, macro pins, stats)
// Build option:
//   L1_TAG_CTRL_STATS_EN  when defined, builds saturating 16-bit lookup and
//                         forward counters; otherwise stat outputs are tied to 0.
module l1_tag_sram_ctrl #(
   parameter int                    DATA_WIDTH = 19,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] CLEAR_WORD = '0
) (
   input  logic              clk,
   input  logic              rst,
   l1_tag_sram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_nxt;
   logic                  rr_inv, rr_inv_nxt;   // 1: invalidate wins the next contested grant

   logic                  fill_gnt, inv_gnt;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic                  flush_busy;
   logic                  fwd_hit;

   // Lookup pipeline: stage 1 is the cycle the macro read is in flight.
   logic                  s1_valid;
   logic                  s1_fwd;
   logic [DATA_WIDTH-1:0] s1_fwd_data;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_tag_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         sweep_cnt <= '0;
         rr_inv    <= 1'b0;
      end else begin
         state     <= state_nxt;
         sweep_cnt <= sweep_cnt_nxt;
         rr_inv    <= rr_inv_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sweep_cnt_nxt = sweep_cnt;
      rr_inv_nxt    = rr_inv;
      fill_gnt      = 1'b0;
      inv_gnt       = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = sweep_cnt;
      wr_data       = CLEAR_WORD;
      case (state)
         ST_IDLE: begin
            // A flush request starves same-cycle writers.
            if (bus.flush_start) begin
               state_nxt = ST_FLUSH;
            end else if (bus.fill_valid && bus.inv_valid) begin
               fill_gnt   = !rr_inv;
               inv_gnt    = rr_inv;
               rr_inv_nxt = !rr_inv;
            end else begin
               fill_gnt = bus.fill_valid;
               inv_gnt  = bus.inv_valid;
            end
            if (fill_gnt) begin
               wr_en   = 1'b1;
               wr_addr = bus.fill_idx;
               wr_data = bus.fill_data;
            end else if (inv_gnt) begin
               wr_en   = 1'b1;
               wr_addr = bus.inv_idx;
               wr_data = CLEAR_WORD;
            end
         end
         ST_FLUSH: begin
            wr_en         = 1'b1;
            sweep_cnt_nxt = sweep_cnt + 1'b1;   // wraps to 0 after the last index
            if (sweep_cnt == '1) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign flush_busy = (state != ST_IDLE);
   assign rd_en      = bus.lookup_valid && !flush_busy;
   assign fwd_hit    = rd_en && wr_en && (wr_addr == bus.lookup_idx);

   // Macro chip selects are forced inactive for as long as reset is held.
   assign bus.sram_csb0  = rst || !wr_en;
   assign bus.sram_addr0 = wr_addr;
   assign bus.sram_din0  = wr_data;
   assign bus.sram_csb1  = rst || !rd_en;
   assign bus.sram_addr1 = bus.lookup_idx;

   assign bus.lookup_ready = !flush_busy;
   assign bus.fill_ready   = fill_gnt;
   assign bus.inv_ready    = inv_gnt;
   assign bus.flush_busy   = flush_busy;
   assign bus.flush_done   = (state == ST_DONE);
   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_tag      = rsp_tag_q;

   // sram_dout1 is only stable from the negedge after the read until just
   // past the following posedge, so it is captured at that posedge. A write
   // that collided with the read at issue time replaces the macro data,
   // which is undefined for a same-address read/write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid    <= 1'b0;
         s1_fwd      <= 1'b0;
         s1_fwd_data <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tag_q   <= '0;
      end else begin
         s1_valid    <= rd_en;
         if (rd_en) begin
            s1_fwd      <= fwd_hit;
            s1_fwd_data <= wr_data;
         end
         rsp_valid_q <= s1_valid;
         if (s1_valid) begin
            rsp_tag_q <= s1_fwd ? s1_fwd_data : bus.sram_dout1;
         end
      end
   end

`ifdef L1_TAG_CTRL_STATS_EN
   logic [15:0] stat_lookups_q;
   logic [15:0] stat_fwd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_lookups_q <= '0;
         stat_fwd_q     <= '0;
      end else begin
         if (rd_en && (stat_lookups_q != 16'hFFFF)) begin
            stat_lookups_q <= stat_lookups_q + 16'd1;
         end
         if (fwd_hit && (stat_fwd_q != 16'hFFFF)) begin
            stat_fwd_q <= stat_fwd_q + 16'd1;
         end
      end
   end

   assign bus.stat_lookups = stat_lookups_q;
   assign bus.stat_fwd     = stat_fwd_q;
`else
   assign bus.stat_lookups = 16'd0;
   assign bus.stat_fwd     = 16'd0;
`endif

endmodule

// File: tb/tb_l1_tag_sram_ctrl.sv
// tb/tb_l1_tag_sram_ctrl.sv - directed self-checking bench for l1_tag_sram_ctrl
module tb_l1_tag_sram_ctrl;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   l1_tag_sram_ctrl_if #(.DATA_WIDTH(19), .ADDR_WIDTH(8)) bus ();

   l1_tag_sram_ctrl #(.DATA_WIDTH(19), .ADDR_WIDTH(8), .CLEAR_WORD(19'h0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef L1_TAG_CTRL_STATS_EN
   localparam int STATS_ON = 1;
`else
   localparam int STATS_ON = 0;
`endif

   // Tag macro model: controls sampled at negedge, array updated at posedge
   // (read-before-write), read data valid from the next negedge until #1
   // after the following posedge, junk otherwise.
   logic [18:0] mem [256];
   logic        m_wen  = 1'b0;
   logic        m_ren  = 1'b0;
   logic [7:0]  m_waddr = 8'h0;
   logic [7:0]  m_raddr = 8'h0;
   logic [18:0] m_wdin = 19'h0;
   logic [18:0] m_pend = 19'h2DEAD;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 19'h10000 | 19'(i);
      bus.sram_dout1 = 19'h2DEAD;
      forever begin
         @(negedge clk);
         bus.sram_dout1 = m_pend;
         m_wen   = !bus.sram_csb0;
         m_waddr = bus.sram_addr0;
         m_wdin  = bus.sram_din0;
         m_ren   = !bus.sram_csb1;
         m_raddr = bus.sram_addr1;
         @(posedge clk);
         if (m_ren) m_pend = mem[m_raddr];
         if (m_wen) mem[m_waddr] = m_wdin;
         #1 bus.sram_dout1 = 19'h2DEAD;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.fill_valid = 1'b1;
      bus.lookup_valid = 1'b1;
      cyc();
      cyc();
      mid();
      total++;
      if ({bus.sram_csb0, bus.sram_csb1} !== 2'b11) begin
         bad++;
         $display("FAIL reset_csb got=%b exp=11", {bus.sram_csb0, bus.sram_csb1});
      end
      total++;
      if ({bus.rsp_valid, bus.rsp_tag, bus.flush_busy, bus.flush_done} !== 22'h0) begin
         bad++;
         $display("FAIL reset_outputs got=%h exp=0", {bus.rsp_valid, bus.rsp_tag, bus.flush_busy, bus.flush_done});
      end
      total++;
      if ({bus.stat_lookups, bus.stat_fwd} !== 32'h0) begin
         bad++;
         $display("FAIL reset_stats got=%h exp=0", {bus.stat_lookups, bus.stat_fwd});
      end
      bus.fill_valid = 1'b0;
      bus.lookup_valid = 1'b0;
      cyc();
      rst = 1'b0;
      mid();
      total++;
      if ({bus.flush_busy, bus.sram_csb0, bus.lookup_ready} !== 3'b011) begin
         bad++;
         $display("FAIL reset_release got=%b exp=011", {bus.flush_busy, bus.sram_csb0, bus.lookup_ready});
      end
      cyc();
   endtask

   task automatic test_rr();
      logic [29:0] exp;
      bus.fill_valid = 1'b1;
      bus.fill_idx   = 8'h05;
      bus.fill_data  = 19'h01234;
      bus.inv_valid  = 1'b1;
      bus.inv_idx    = 8'h06;
      for (int i = 0; i < 3; i++) begin
         mid();
         if (i == 1) exp = {1'b0, 1'b1, 1'b0, 8'h06, 19'h00000};
         else        exp = {1'b1, 1'b0, 1'b0, 8'h05, 19'h01234};
         total++;
         if ({bus.fill_ready, bus.inv_ready, bus.sram_csb0, bus.sram_addr0, bus.sram_din0} !== exp) begin
            bad++;
            $display("FAIL rr_cycle%0d got=%h exp=%h", i,
                     {bus.fill_ready, bus.inv_ready, bus.sram_csb0, bus.sram_addr0, bus.sram_din0}, exp);
         end
         cyc();
      end
      bus.fill_valid = 1'b0;
      bus.inv_valid  = 1'b0;
   endtask

   task automatic test_fill_lookup();
      bus.fill_valid = 1'b1;
      bus.fill_idx   = 8'h12;
      bus.fill_data  = 19'h4ABCD;
      mid();
      total++;
      if (bus.fill_ready !== 1'b1) begin
         bad++;
         $display("FAIL fill_grant got=%b exp=1", bus.fill_ready);
      end
      cyc();
      bus.fill_valid   = 1'b0;
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = 8'h12;
      mid();
      total++;
      if ({bus.lookup_ready, bus.sram_csb1, bus.sram_addr1} !== {1'b1, 1'b0, 8'h12}) begin
         bad++;
         $display("FAIL lookup_issue got=%h exp=%h", {bus.lookup_ready, bus.sram_csb1, bus.sram_addr1}, {1'b1, 1'b0, 8'h12});
      end
      cyc();
      bus.lookup_valid = 1'b0;
      mid();
      total++;
      if (bus.rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL lookup_early_rsp got=%b exp=0", bus.rsp_valid);
      end
      cyc();
      mid();
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 19'h4ABCD}) begin
         bad++;
         $display("FAIL lookup_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_tag}, {1'b1, 19'h4ABCD});
      end
      cyc();
      mid();
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b0, 19'h4ABCD}) begin
         bad++;
         $display("FAIL lookup_rsp_hold got=%h exp=%h", {bus.rsp_valid, bus.rsp_tag}, {1'b0, 19'h4ABCD});
      end
      cyc();
   endtask

   task automatic test_collision();
      bus.fill_valid   = 1'b1;
      bus.fill_idx     = 8'h40;
      bus.fill_data    = 19'h7FFFF;
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = 8'h40;
      cyc();
      bus.fill_valid   = 1'b0;
      bus.lookup_valid = 1'b0;
      cyc();
      mid();
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 19'h7FFFF}) begin
         bad++;
         $display("FAIL collision_fwd got=%h exp=%h", {bus.rsp_valid, bus.rsp_tag}, {1'b1, 19'h7FFFF});
      end
      total++;
      if (bus.stat_fwd !== 16'(STATS_ON)) begin
         bad++;
         $display("FAIL collision_stat_fwd got=%0d exp=%0d", bus.stat_fwd, STATS_ON);
      end
      cyc();
      // write to the looked-up index one cycle later must not leak into the response
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = 8'h41;
      cyc();
      bus.lookup_valid = 1'b0;
      bus.fill_valid   = 1'b1;
      bus.fill_idx     = 8'h41;
      bus.fill_data    = 19'h00003;
      cyc();
      bus.fill_valid   = 1'b0;
      mid();
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 19'h10041}) begin
         bad++;
         $display("FAIL late_write_no_fwd got=%h exp=%h", {bus.rsp_valid, bus.rsp_tag}, {1'b1, 19'h10041});
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      logic [18:0] t [4];
      t[0] = 19'h11; t[1] = 19'h22; t[2] = 19'h33; t[3] = 19'h44;
      for (int i = 0; i < 4; i++) begin
         bus.fill_valid = 1'b1;
         bus.fill_idx   = 8'(i + 1);
         bus.fill_data  = t[i];
         cyc();
      end
      bus.fill_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.lookup_valid = (k < 4);
         bus.lookup_idx   = 8'(k + 1);
         mid();
         total++;
         if (k >= 2 && k <= 5) begin
            if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, t[k-2]}) begin
               bad++;
               $display("FAIL b2b_rsp%0d got=%h exp=%h", k, {bus.rsp_valid, bus.rsp_tag}, {1'b1, t[k-2]});
            end
         end else if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle%0d got=%b exp=0", k, bus.rsp_valid);
         end
         cyc();
      end
      bus.lookup_valid = 1'b0;
      total++;
      if (bus.stat_lookups !== 16'(7 * STATS_ON)) begin
         bad++;
         $display("FAIL stat_lookups got=%0d exp=%0d", bus.stat_lookups, 7 * STATS_ON);
      end
   endtask

   task automatic test_flush();
      logic [6:0] exp;
      logic [6:0] got;
      for (int k = 0; k <= 258; k++) begin
         bus.flush_start  = (k == 0);
         bus.fill_valid   = (k <= 257);
         bus.fill_idx     = 8'h33;
         bus.fill_data    = 19'h00055;
         bus.inv_valid    = (k <= 257);
         bus.inv_idx      = 8'h34;
         bus.lookup_valid = (k >= 1 && k <= 257);
         bus.lookup_idx   = 8'h12;
         mid();
         if (k == 0 || k == 258) exp = 7'b1000011;
         else if (k == 257)      exp = 7'b0001111;
         else                    exp = 7'b0001001;
         got = {bus.lookup_ready, bus.fill_ready, bus.inv_ready, bus.flush_busy,
                bus.flush_done, bus.sram_csb0, bus.sram_csb1};
         total++;
         if (got !== exp) begin
            bad++;
            $display("FAIL flush_flags%0d got=%b exp=%b", k, got, exp);
         end
         if (k >= 1 && k <= 256) begin
            total++;
            if ({bus.sram_addr0, bus.sram_din0} !== {8'(k - 1), 19'h0}) begin
               bad++;
               $display("FAIL flush_addr%0d got=%h exp=%h", k, {bus.sram_addr0, bus.sram_din0}, {8'(k - 1), 19'h0});
            end
         end
         cyc();
      end
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = 8'h12;
      cyc();
      bus.lookup_valid = 1'b0;
      cyc();
      mid();
      total++;
      if ({bus.rsp_valid, bus.rsp_tag} !== {1'b1, 19'h0}) begin
         bad++;
         $display("FAIL flush_cleared got=%h exp=%h", {bus.rsp_valid, bus.rsp_tag}, {1'b1, 19'h0});
      end
      cyc();
   endtask

   task automatic test_reset_mid_flush();
      int done_cnt;
      int done_at;
      bus.flush_start = 1'b1;
      cyc();
      bus.flush_start = 1'b0;
      repeat (128) cyc();
      mid();
      total++;
      if ({bus.sram_csb0, bus.sram_addr0} !== {1'b0, 8'h80}) begin
         bad++;
         $display("FAIL midflush_pos got=%h exp=%h", {bus.sram_csb0, bus.sram_addr0}, {1'b0, 8'h80});
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if ({bus.flush_busy, bus.flush_done, bus.sram_csb0, bus.sram_csb1, bus.rsp_valid} !== 5'b00110) begin
         bad++;
         $display("FAIL midflush_reset got=%b exp=00110",
                  {bus.flush_busy, bus.flush_done, bus.sram_csb0, bus.sram_csb1, bus.rsp_valid});
      end
      total++;
      if (bus.stat_lookups !== 16'h0) begin
         bad++;
         $display("FAIL midflush_stats got=%0d exp=0", bus.stat_lookups);
      end
      cyc();
      rst = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         mid();
         if (bus.flush_done || bus.flush_busy) done_cnt++;
         cyc();
      end
      total++;
      if (done_cnt !== 0) begin
         bad++;
         $display("FAIL midflush_quiet got=%0d exp=0", done_cnt);
      end
      bus.flush_start = 1'b1;
      cyc();
      bus.flush_start = 1'b0;
      mid();
      total++;
      if ({bus.flush_busy, bus.sram_csb0, bus.sram_addr0} !== {1'b1, 1'b0, 8'h00}) begin
         bad++;
         $display("FAIL reflush_start got=%h exp=%h", {bus.flush_busy, bus.sram_csb0, bus.sram_addr0}, {1'b1, 1'b0, 8'h00});
      end
      done_at = -1;
      for (int i = 2; i < 400; i++) begin
         cyc();
         mid();
         if (bus.flush_done) begin
            done_at = i;
            break;
         end
      end
      total++;
      if (done_at !== 257) begin
         bad++;
         $display("FAIL reflush_done_cycle got=%0d exp=257", done_at);
      end
      cyc();
   endtask

   task automatic test_inflight_drop();
      bus.lookup_valid = 1'b1;
      bus.lookup_idx   = 8'h12;
      cyc();
      bus.lookup_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mid();
         total++;
         if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL inflight_drop%0d got=%b exp=0", i, bus.rsp_valid);
         end
         cyc();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.lookup_valid = 1'b0;
      bus.lookup_idx   = 8'h0;
      bus.fill_valid   = 1'b0;
      bus.fill_idx     = 8'h0;
      bus.fill_data    = 19'h0;
      bus.inv_valid    = 1'b0;
      bus.inv_idx      = 8'h0;
      bus.flush_start  = 1'b0;
      test_reset();
      test_rr();
      test_fill_lookup();
      test_collision();
      test_back_to_back();
      test_flush();
      test_reset_mid_flush();
      test_inflight_drop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/l1_tag_sram_ctrl.md
Name: l1_tag_sram_ctrl

Overview:
Sequencing and arbitration controller in front of the L1-cache tag array macro (1 write port, 1 read port, 19-bit x 256). It shares the single write port between refill (fill) and invalidate requesters. It runs a full-array flush sweep and issues lookups on the read port. It registers the macro's transient read data and forwards write data on same-cycle same-address read/write collisions.

Parameters:
DATA_WIDTH, 19, tag word width (bit DATA_WIDTH-1 = valid)
ADDR_WIDTH, 8, index width; depth = 1<<ADDR_WIDTH
CLEAR_WORD, 0, word written by invalidate and flush

Ports:
clk  in  1  single clock; drives both macro clocks
rst  in  1  asynchronous, active-high reset
lookup_valid  in  1  read request
lookup_ready  out  1  read accepted when valid&ready
lookup_idx  in  ADDR_WIDTH  read index
rsp_valid  out  1  one-cycle read response strobe
rsp_tag  out  DATA_WIDTH  read data, held until next response
fill_valid  in  1  refill write request
fill_ready  out  1  fill grant
fill_idx  in  ADDR_WIDTH  fill index
fill_data  in  DATA_WIDTH  fill word
inv_valid  in  1  invalidate request
inv_ready  out  1  invalidate grant
inv_idx  in  ADDR_WIDTH  invalidate index
flush_start  in  1  start full-array clear
flush_busy  out  1  sweep in progress
flush_done  out  1  one-cycle pulse at sweep end
sram_csb0  out  1  write port chip select, active low
sram_addr0  out  ADDR_WIDTH  write address
sram_din0  out  DATA_WIDTH  write data
sram_csb1  out  1  read port chip select, active low
sram_addr1  out  ADDR_WIDTH  read address
sram_dout1  in  DATA_WIDTH  read data (valid only from negedge to just after next posedge)
stat_lookups  out  16  lookup count (optional feature)
stat_fwd  out  16  forward count (optional feature)

Behaviour:
- Reset values (async, rst=1): FSM=IDLE, sweep counter=0, rr pointer=fill, rsp_valid=0, rsp_tag=0, flush_busy=0, flush_done=0, stats=0. Both csb=1 while rst is high.
- FSM states:
  - IDLE: flush_start=1 goes to FLUSH. flush_start has priority over same-cycle fill and invalidate, which are not granted that cycle.
  - FLUSH: writes CLEAR_WORD at counter each cycle, counter++. After idx 255 is written, goes to DONE.
  - DONE: flush_done=1 for one cycle, then IDLE.
  - flush_start is ignored outside IDLE.
- flush_busy=1 in FLUSH and DONE. lookup_ready, fill_ready and inv_ready are all 0 during flush_busy.
- Sweep takes exactly 256 write cycles. Counter wraps 255 to 0 on exit.
- Write port arbitration (IDLE):
  - Only one of fill and invalidate present: it is granted.
  - Both present: round-robin. Pointer toggles only after a contested grant. After reset, fill wins first.
- Write grant drives sram_csb0=0, addr0 and din0 combinationally in the same cycle. din0 = fill_data, or CLEAR_WORD for invalidate.
- lookup_ready = !flush_busy, with no backpressure otherwise. Handshake drives sram_csb1=0 and addr1=lookup_idx combinationally.
- Read latency: handshake in cycle N. Controller registers sram_dout1 at the posedge ending cycle N+1. rsp_valid=1 and rsp_tag valid in cycle N+2.
- Collision: a write granted in cycle N to lookup_idx of a lookup accepted in cycle N gives rsp_tag = that write word, not sram_dout1.
- A write in cycle N+1 to the same index does not affect the response.
- Back-to-back lookups: one response per cycle, in order.
- Reset mid-flush: sweep abandoned, no flush_done. In-flight lookup responses are dropped (rsp_valid=0).

Optional Feature:
L1_TAG_CTRL_STATS_EN:
- Defined: stat_lookups increments per accepted lookup. stat_fwd increments per collision forward. Both 16-bit, saturate at 0xFFFF, async-reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- Reset, fill idx 0x12 data 0x4ABCD, then lookup 0x12 -> rsp_valid two cycles after the lookup handshake, rsp_tag=0x4ABCD.
- fill and inv both valid for 3 cycles from reset, different idx -> grants fill, inv, fill. csb0=0 each cycle. inv din0=0.
- Same cycle: fill idx 0x40 data 0x7FFFF and lookup idx 0x40 -> rsp_tag=0x7FFFF. stat_fwd=1 with STATS_EN.
- flush_start pulse -> flush_busy for 257 cycles, sram_addr0 steps 0x00..0xFF, all readies 0, flush_done pulse once. Then lookup 0x12 -> rsp_tag=0.
- Assert rst at sweep idx 0x80 -> outputs return to reset values at once, no flush_done. Next flush_start restarts at idx 0.
- 4 back-to-back lookups to idx 1,2,3,4 preloaded with 0x11,0x22,0x33,0x44 -> 4 consecutive rsp_valid cycles with tags in order.
